// File: rtl/outport_sw_allocator.sv
`default_nettype none
// ============================================================================
// Module   : outport_sw_allocator
// Brief    : Round-robin wormhole switch allocator for a single output port,
//            gated by a downstream credit counter.
// Revision : 1.0
// ============================================================================
module outport_sw_allocator #(
    parameter int IN_PORTS  = 7,
    parameter int LOG_PORTS = 3,
    parameter int CREDITS   = 4,
    parameter int CREDIT_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_PORTS-1:0]  req,
    input  logic [IN_PORTS-1:0]  is_head,
    input  logic [IN_PORTS-1:0]  is_tail,
    input  logic                 credit_in,
    output logic [IN_PORTS-1:0]  grant,
    output logic [LOG_PORTS-1:0] grant_id,
    output logic                 grant_valid,
    output logic                 xfer,
    output logic [CREDIT_W-1:0]  credit_cnt,
    output logic                 credit_err
);

    localparam logic [CREDIT_W-1:0]  c_credit_max = CREDIT_W'(CREDITS);
    localparam logic [LOG_PORTS-1:0] c_rr_reset   = LOG_PORTS'(IN_PORTS - 1);
    localparam logic [IN_PORTS-1:0]  c_onehot_lsb = IN_PORTS'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IN_PORTS-1:0]    r_grant;
    logic [IN_PORTS-1:0]    w_grant_nxt;
    logic [LOG_PORTS-1:0]   r_grant_id;
    logic [LOG_PORTS-1:0]   w_grant_id_nxt;
    logic                   r_grant_valid;
    logic                   w_grant_valid_nxt;
    logic [LOG_PORTS-1:0]   r_rr_ptr;
    logic [LOG_PORTS-1:0]   w_rr_ptr_nxt;
    logic [CREDIT_W-1:0]    r_credit_cnt;
    logic [CREDIT_W-1:0]    w_credit_cnt_nxt;
    logic                   r_credit_err;
    logic                   w_credit_err_nxt;

    logic                   w_has_credit;
    logic [IN_PORTS-1:0]    w_eligible;
    logic                   w_owner_req;
    logic                   w_owner_tail;
    logic                   w_xfer;
    logic                   w_pick_found;
    logic [LOG_PORTS-1:0]   w_pick_id;
    int                     w_idx;

    assign w_has_credit = (r_credit_cnt != '0);
    assign w_owner_req  = req[r_grant_id];
    assign w_owner_tail = is_tail[r_grant_id];
    assign w_xfer       = r_grant_valid & w_owner_req & w_has_credit;

    // Only head flits may open a packet, and only when a downstream slot exists.
    generate
        for (genvar gi = 0; gi < IN_PORTS; gi++) begin : g_eligible
            assign w_eligible[gi] = req[gi] & is_head[gi] & w_has_credit;
        end
    endgenerate

    // Search starts one past the last owner, so that owner has lowest priority.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick_id    = '0;
        w_idx        = 0;
        for (int k = 1; k <= IN_PORTS; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % IN_PORTS;
            if (!w_pick_found && w_eligible[w_idx]) begin
                w_pick_found = 1'b1;
                w_pick_id    = LOG_PORTS'(w_idx);
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_id_nxt    = r_grant_id;
        w_grant_valid_nxt = r_grant_valid;
        w_rr_ptr_nxt      = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt       = ST_LOCKED;
                    w_grant_nxt       = c_onehot_lsb << w_pick_id;
                    w_grant_id_nxt    = w_pick_id;
                    w_grant_valid_nxt = 1'b1;
                end
            end
            ST_LOCKED: begin
                // grant_id is kept after release; only grant/grant_valid drop.
                if (w_xfer && w_owner_tail) begin
                    w_state_nxt       = ST_IDLE;
                    w_grant_nxt       = '0;
                    w_grant_valid_nxt = 1'b0;
                    w_rr_ptr_nxt      = r_grant_id;
                end
            end
            default: begin
                w_state_nxt       = ST_IDLE;
                w_grant_nxt       = '0;
                w_grant_valid_nxt = 1'b0;
            end
        endcase
    end

    always_comb begin
        w_credit_cnt_nxt = r_credit_cnt;
        w_credit_err_nxt = r_credit_err;
        case ({w_xfer, credit_in})
            2'b10: w_credit_cnt_nxt = r_credit_cnt - CREDIT_W'(1);
            2'b01: begin
                if (r_credit_cnt == c_credit_max) begin
                    w_credit_err_nxt = 1'b1;
                end else begin
                    w_credit_cnt_nxt = r_credit_cnt + CREDIT_W'(1);
                end
            end
            default: w_credit_cnt_nxt = r_credit_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_id    <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= c_rr_reset;
            r_credit_cnt  <= c_credit_max;
            r_credit_err  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_id    <= w_grant_id_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_credit_cnt  <= w_credit_cnt_nxt;
            r_credit_err  <= w_credit_err_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = r_grant_valid;
    assign xfer        = w_xfer;
    assign credit_cnt  = r_credit_cnt;
    assign credit_err  = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_outport_sw_allocator.sv
`default_nettype none
// ============================================================================
// Module   : tb_outport_sw_allocator
// Brief    : Directed cycle-by-cycle vectors with hand-computed expectations.
// Revision : 1.0
// ============================================================================
module tb_outport_sw_allocator;

    logic       clk;
    logic       rst_n;
    logic [6:0] req;
    logic [6:0] is_head;
    logic [6:0] is_tail;
    logic       credit_in;
    logic [6:0] grant;
    logic [2:0] grant_id;
    logic       grant_valid;
    logic       xfer;
    logic [2:0] credit_cnt;
    logic       credit_err;

    int checks = 0;
    int errors = 0;

    outport_sw_allocator #(
        .IN_PORTS  (7),
        .LOG_PORTS (3),
        .CREDITS   (4),
        .CREDIT_W  (3)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .is_head     (is_head),
        .is_tail     (is_tail),
        .credit_in   (credit_in),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .xfer        (xfer),
        .credit_cnt  (credit_cnt),
        .credit_err  (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rstn;
        logic [6:0] rq;
        logic [6:0] hd;
        logic [6:0] tl;
        logic       cin;
        logic [6:0] eg;
        logic [2:0] egid;
        logic       egv;
        logic       ex;
        logic [2:0] ecnt;
        logic       eerr;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic add(input logic rstn, input logic [6:0] rq, input logic [6:0] hd,
                       input logic [6:0] tl, input logic cin, input logic [6:0] eg,
                       input logic [2:0] egid, input logic egv, input logic ex,
                       input logic [2:0] ecnt, input logic eerr);
        vec_t t;
        t.rstn = rstn; t.rq = rq; t.hd = hd; t.tl = tl; t.cin = cin;
        t.eg = eg; t.egid = egid; t.egv = egv; t.ex = ex; t.ecnt = ecnt; t.eerr = eerr;
        vq.push_back(t);
    endtask

    initial begin
        // Single-flit packet on port 0, then return the credit.
        add(1'b1, 7'b0000001, 7'b0000001, 7'b0000001, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b1, 7'b0000001, 7'b0000001, 7'b0000001, 1'b0, 7'b0000001, 3'd0, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0);
        // Ports 2 and 5 contend with 3-flit packets; credit returned on every xfer.
        add(1'b1, 7'b0100100, 7'b0100100, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0100100, 7'b0000000, 1'b1, 7'b0000100, 3'd2, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0100000, 7'b0000000, 1'b1, 7'b0000100, 3'd2, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0100000, 7'b0000100, 1'b1, 7'b0000100, 3'd2, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0100100, 7'b0000000, 1'b0, 7'b0000000, 3'd2, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0100100, 7'b0000000, 1'b1, 7'b0100000, 3'd5, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0000100, 7'b0000000, 1'b1, 7'b0100000, 3'd5, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0000100, 7'b0100000, 1'b1, 7'b0100000, 3'd5, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0100100, 7'b0000000, 1'b0, 7'b0000000, 3'd5, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0100100, 7'b0000000, 1'b1, 7'b0000100, 3'd2, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0100000, 7'b0000000, 1'b1, 7'b0000100, 3'd2, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0100100, 7'b0100000, 7'b0000100, 1'b1, 7'b0000100, 3'd2, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 7'b0000000, 3'd2, 1'b0, 1'b0, 3'd4, 1'b0);
        // Port 3 owns, port 1 requests mid-packet, port 3 stalls once, then tail.
        add(1'b1, 7'b0001000, 7'b0001000, 7'b0000000, 1'b0, 7'b0000000, 3'd2, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b1, 7'b0001000, 7'b0001000, 7'b0000000, 1'b0, 7'b0001000, 3'd3, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0001010, 7'b0000010, 7'b0000000, 1'b0, 7'b0001000, 3'd3, 1'b1, 1'b1, 3'd3, 1'b0);
        add(1'b1, 7'b0000010, 7'b0000010, 7'b0000000, 1'b0, 7'b0001000, 3'd3, 1'b1, 1'b0, 3'd2, 1'b0);
        add(1'b1, 7'b0001010, 7'b0000010, 7'b0001000, 1'b0, 7'b0001000, 3'd3, 1'b1, 1'b1, 3'd2, 1'b0);
        add(1'b1, 7'b0000010, 7'b0000010, 7'b0000000, 1'b0, 7'b0000000, 3'd3, 1'b0, 1'b0, 3'd1, 1'b0);
        add(1'b1, 7'b0000010, 7'b0000010, 7'b0000010, 1'b0, 7'b0000010, 3'd1, 1'b1, 1'b1, 3'd1, 1'b0);
        // Zero credits: head request pending but no grant.
        add(1'b1, 7'b0000001, 7'b0000001, 7'b0000001, 1'b0, 7'b0000000, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0);
        add(1'b1, 7'b0000001, 7'b0000001, 7'b0000001, 1'b1, 7'b0000000, 3'd1, 1'b0, 1'b0, 3'd0, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 3'd1, 1'b0, 1'b0, 3'd1, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 3'd1, 1'b0, 1'b0, 3'd2, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 3'd1, 1'b0, 1'b0, 3'd3, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 7'b0000000, 3'd1, 1'b0, 1'b0, 3'd4, 1'b0);
        // 5-flit packet on port 6 runs out of credits after flit 4.
        add(1'b1, 7'b1000000, 7'b1000000, 7'b0000000, 1'b0, 7'b0000000, 3'd1, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b1, 7'b1000000, 7'b1000000, 7'b0000000, 1'b0, 7'b1000000, 3'd6, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b1000000, 7'b0000000, 7'b0000000, 1'b0, 7'b1000000, 3'd6, 1'b1, 1'b1, 3'd3, 1'b0);
        add(1'b1, 7'b1000000, 7'b0000000, 7'b0000000, 1'b0, 7'b1000000, 3'd6, 1'b1, 1'b1, 3'd2, 1'b0);
        add(1'b1, 7'b1000000, 7'b0000000, 7'b0000000, 1'b0, 7'b1000000, 3'd6, 1'b1, 1'b1, 3'd1, 1'b0);
        add(1'b1, 7'b1000000, 7'b0000000, 7'b1000000, 1'b0, 7'b1000000, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0);
        add(1'b1, 7'b1000000, 7'b0000000, 7'b1000000, 1'b1, 7'b1000000, 3'd6, 1'b1, 1'b0, 3'd0, 1'b0);
        add(1'b1, 7'b1000000, 7'b0000000, 7'b1000000, 1'b0, 7'b1000000, 3'd6, 1'b1, 1'b1, 3'd1, 1'b0);
        // Refill, then one credit too many sets the sticky error.
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 3'd6, 1'b0, 1'b0, 3'd0, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 3'd6, 1'b0, 1'b0, 3'd1, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 3'd6, 1'b0, 1'b0, 3'd2, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 3'd6, 1'b0, 1'b0, 3'd3, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b1, 7'b0000000, 3'd6, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 7'b0000000, 3'd6, 1'b0, 1'b0, 3'd4, 1'b1);
        add(1'b1, 7'b0000001, 7'b0000001, 7'b0000001, 1'b0, 7'b0000000, 3'd6, 1'b0, 1'b0, 3'd4, 1'b1);
        add(1'b1, 7'b0000001, 7'b0000001, 7'b0000001, 1'b0, 7'b0000001, 3'd0, 1'b1, 1'b1, 3'd4, 1'b1);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1);
        // Reset while port 4 is mid-packet; afterwards port 0 beats port 6.
        add(1'b1, 7'b0010000, 7'b0010000, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1);
        add(1'b1, 7'b0010000, 7'b0010000, 7'b0000000, 1'b0, 7'b0010000, 3'd4, 1'b1, 1'b1, 3'd3, 1'b1);
        add(1'b0, 7'b0010000, 7'b0000000, 7'b0000000, 1'b0, 7'b0010000, 3'd4, 1'b1, 1'b1, 3'd2, 1'b1);
        add(1'b1, 7'b1000001, 7'b1000001, 7'b1000001, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, 3'd4, 1'b0);
        add(1'b1, 7'b1000001, 7'b1000001, 7'b1000001, 1'b0, 7'b0000001, 3'd0, 1'b1, 1'b1, 3'd4, 1'b0);
        add(1'b1, 7'b0000000, 7'b0000000, 7'b0000000, 1'b0, 7'b0000000, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0);

        rst_n     = 1'b0;
        req       = '0;
        is_head   = '0;
        is_tail   = '0;
        credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",       32'(grant),       32'h0);
        check("rst_grant_id",    32'(grant_id),    32'h0);
        check("rst_grant_valid", 32'(grant_valid), 32'h0);
        check("rst_xfer",        32'(xfer),        32'h0);
        check("rst_credit_cnt",  32'(credit_cnt),  32'h4);
        check("rst_credit_err",  32'(credit_err),  32'h0);

        foreach (vq[i]) begin
            rst_n     = vq[i].rstn;
            req       = vq[i].rq;
            is_head   = vq[i].hd;
            is_tail   = vq[i].tl;
            credit_in = vq[i].cin;
            #1;
            check($sformatf("v%0d_grant", i),       32'(grant),       32'(vq[i].eg));
            check($sformatf("v%0d_grant_id", i),    32'(grant_id),    32'(vq[i].egid));
            check($sformatf("v%0d_grant_valid", i), 32'(grant_valid), 32'(vq[i].egv));
            check($sformatf("v%0d_xfer", i),        32'(xfer),        32'(vq[i].ex));
            check($sformatf("v%0d_credit_cnt", i),  32'(credit_cnt),  32'(vq[i].ecnt));
            check($sformatf("v%0d_credit_err", i),  32'(credit_err),  32'(vq[i].eerr));
            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/outport_sw_allocator.md
Name: outport_sw_allocator

Overview:
- Per-output-port switch allocator for the wormhole router; one instance per output port.
- Arbitrates the router's 7 input ports' head-flit requests for this output port using round-robin.
- Holds the grant for the whole packet, head to tail.
- Tracks downstream buffer credits, so flits only move when the next hop has space.
- Sits between the routing/priority logic, which produces per-inport requests, and the crossbar select for this output.

Parameters:
- IN_PORTS, 7, number of requesting input ports.
- LOG_PORTS, 3, width of port index; ceil(log2(IN_PORTS)).
- CREDITS, 4, downstream buffer depth in flits; reset value of the credit counter.
- CREDIT_W, 3, credit counter width; must hold 0..CREDITS.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  synchronous reset, active low.
- req  input  IN_PORTS  inport i has a valid flit routed to this outport.
- is_head  input  IN_PORTS  flit presented by inport i is a head flit.
- is_tail  input  IN_PORTS  flit presented by inport i is a tail flit; head and tail together means a single-flit packet.
- credit_in  input  1  downstream freed one buffer slot this cycle.
- grant  output  IN_PORTS  one-hot crossbar select; registered.
- grant_id  output  LOG_PORTS  index of the owning inport; registered.
- grant_valid  output  1  outport is locked to grant_id.
- xfer  output  1  flit moves this cycle (combinational).
- credit_cnt  output  CREDIT_W  current downstream credits.
- credit_err  output  1  sticky; credit_in arrived while credit_cnt==CREDITS.

Behaviour:
- Reset values (rst_n=0 at a clock edge):
  - state=IDLE.
  - grant=0, grant_id=0, grant_valid=0.
  - credit_cnt=CREDITS, credit_err=0.
  - rr_ptr=IN_PORTS-1, so port 0 has highest priority first.
  - Reset applied mid-packet discards ownership immediately; no flush.
- IDLE state:
  - Eligible set: inports with req[i]=1 and is_head[i]=1, evaluated only when credit_cnt!=0.
  - If the set is non-empty, pick the first eligible i searching rr_ptr+1, rr_ptr+2, ... modulo IN_PORTS.
  - Register grant=1<<i, grant_id=i, grant_valid=1, and go to LOCKED.
  - Latency: request sampled in cycle N gives grant visible in cycle N+1.
  - Non-head requests in IDLE are ignored.
  - credit_cnt==0 means no grant, even with head requests pending.
- LOCKED state:
  - xfer = grant_valid & req[grant_id] & (credit_cnt!=0).
  - Other inports' requests are ignored.
  - If the owner deasserts req, grant is held and xfer=0 (wormhole hold).
  - On xfer with is_tail[grant_id]=1: next state IDLE, grant=0, grant_valid=0, rr_ptr=grant_id; grant_id keeps its last value.
  - One idle cycle between packets is mandatory: tail in cycle N, re-arbitration in cycle N+1, new grant in cycle N+2.
- Credit counter:
  - xfer only → credit_cnt-1.
  - credit_in only → credit_cnt+1.
  - Both in the same cycle → unchanged.
  - credit_in while credit_cnt==CREDITS and no xfer → counter saturates at CREDITS and credit_err is set; it clears only on reset.
  - The counter never underflows, because xfer requires credit_cnt!=0.
- rr_ptr changes only on tail completion; IDLE cycles without a grant leave it unchanged.
- Invariants:
  - grant is one-hot when grant_valid=1, and zero otherwise.
  - xfer=0 whenever grant_valid=0.

Test Plan:
- Reset, then req=7'b0000001 with port 0 head+tail single flit → grant=0000001 and grant_id=0 at cycle+1; xfer=1 that cycle; credit_cnt 4→3; grant_valid=0 the following cycle.
- Ports 2 and 5 hold head requests continuously, each sending 3-flit packets → order is port 2 then port 5 then port 2. Each grant is held exactly 3 xfer cycles, with one idle cycle between packets.
- Owner port 3 mid-packet while port 1 raises a head request → grant stays on port 3 until port 3's tail xfer; port 1 is granted two cycles after that tail.
- No credit_in, 5-flit packet with CREDITS=4 → 4 xfers, then xfer=0 with credit_cnt=0 and grant held. A credit_in pulse gives credit_cnt 0→1, then xfer of flit 5 (tail), credit_cnt→0, release.
- Simultaneous xfer and credit_in → credit_cnt unchanged. Extra credit_in at credit_cnt=4 → stays 4 and credit_err=1, sticky until rst_n=0.
- rst_n=0 while port 4 is locked mid-packet → next cycle grant=0, grant_valid=0, credit_cnt=4, credit_err=0. First post-reset arbitration between ports 0 and 6 grants port 0.
